// File: rtl/decoder_seq_param.sv
// decoder_seq_param: registered SEL_W-to-2**SEL_W one-hot decoder with valid/ready commands and auto-scan.
// Define DEC_GRAY_IN_EN to treat in_sel as Gray code.
module decoder_seq_param #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic [1:0]            in_mode,
   input  logic [DWELL_W-1:0]    in_dwell,
   output logic [2**SEL_W-1:0]   out_0,
   output logic                  out_valid,
   output logic                  busy
);
   localparam int OUT_W = 2**SEL_W;
   localparam logic [OUT_W-1:0] ONE = OUT_W'(1);
   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
   state_t             state_q;
   logic [SEL_W-1:0]   sel_bin, pos_q, pos_d, lap_q;
   logic [DWELL_W-1:0] cnt_q, dwell_q;
   logic [OUT_W-1:0]   out_q;
   logic               down_q, valid_q, busy_q;
`ifdef DEC_GRAY_IN_EN
   always_comb begin
      sel_bin = '0;
      for (int i = 0; i < SEL_W; i++) sel_bin[i] = ^(in_sel >> i);
   end
`else
   assign sel_bin = in_sel;
`endif
   assign pos_d     = down_q ? pos_q - SEL_W'(1) : pos_q + SEL_W'(1);
   assign in_ready  = state_q != SCAN;
   assign out_0     = out_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         pos_q   <= '0;
         cnt_q   <= '0;
         lap_q   <= '0;
         dwell_q <= '0;
         down_q  <= 1'b0;
      end else if (state_q == SCAN) begin
         // lap_q counts positions already left; all-ones means the last position is showing
         if (cnt_q != dwell_q) cnt_q <= cnt_q + DWELL_W'(1);
         else if (&lap_q) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            cnt_q <= '0;
            lap_q <= lap_q + SEL_W'(1);
            pos_q <= pos_d;
            out_q <= ONE << pos_d;
         end
      end else if (in_valid) begin
         pos_q   <= sel_bin;
         cnt_q   <= '0;
         lap_q   <= '0;
         dwell_q <= in_dwell;
         down_q  <= in_mode == 2'b10;
         state_q <= in_mode == 2'b11 ? IDLE : in_mode == 2'b00 ? HOLD : SCAN;
         out_q   <= in_mode == 2'b11 ? '0 : ONE << sel_bin;
         valid_q <= in_mode != 2'b11;
         busy_q  <= in_mode[0] ^ in_mode[1];
      end
   end
endmodule

// File: tb/tb_decoder_seq_param.sv
// tb_decoder_seq_param: directed stimulus against an elapsed-time model of the decoder/scanner.
module tb_decoder_seq_param;
   localparam int OUT_W = 8;
   logic       sys_clk = 1'b0, sys_rst = 1'b1, in_valid = 1'b0;
   logic [2:0] in_sel = '0;
   logic [1:0] in_mode = '0;
   logic [7:0] in_dwell = '0;
   logic       in_ready, out_valid, busy;
   logic [7:0] out_0;
   int passed = 0, total = 0;
   int edge_n = 0, m_t0 = 0, m_kind = 0, m_sel = 0, m_dir = 0, m_dwell = 0;
   bit chk_en = 1'b0;
   int up_seq[8] = '{6, 7, 0, 1, 2, 3, 4, 5};
   int dn_seq[8] = '{1, 0, 7, 6, 5, 4, 3, 2};

   always #5 sys_clk = ~sys_clk;

   decoder_seq_param dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_mode(in_mode), .in_dwell(in_dwell),
      .out_0(out_0), .out_valid(out_valid), .busy(busy)
   );

   function automatic void check(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
   endfunction

   function automatic logic [2:0] enc(input int b);
      logic [2:0] v = 3'(b);
`ifdef DEC_GRAY_IN_EN
      return v ^ (v >> 1);
`else
      return v;
`endif
   endfunction

   function automatic int to_bin(input logic [2:0] s);
`ifdef DEC_GRAY_IN_EN
      for (int v = 0; v < 8; v++) if (3'(v ^ (v >> 1)) == s) return v;
      return 0;
`else
      return int'(s);
`endif
   endfunction

   // Scan output depends only on cycles elapsed since the accept.
   function automatic bit m_busy();
      return m_kind == 2 && (edge_n - m_t0) < OUT_W * (m_dwell + 1);
   endfunction

   function automatic int m_pos();
      int k;
      if (m_kind != 2) return m_sel;
      k = (edge_n - m_t0) / (m_dwell + 1);
      if (k > OUT_W - 1) k = OUT_W - 1;
      return m_dir ? (m_sel - k + OUT_W) % OUT_W : (m_sel + k) % OUT_W;
   endfunction

   always @(posedge sys_clk) begin
      if (sys_rst) m_kind = 0;
      else if (in_valid && !m_busy()) begin
         m_t0    = edge_n + 1;
         m_sel   = to_bin(in_sel);
         m_dwell = int'(in_dwell);
         m_dir   = (in_mode == 2'b10) ? 1 : 0;
         m_kind  = in_mode == 2'b00 ? 1 : in_mode == 2'b11 ? 0 : 2;
      end
      edge_n++;
   end

   always @(negedge sys_clk) begin
      if (chk_en) begin
         check("model_out_0", 32'(out_0), m_kind == 0 ? 32'd0 : 32'd1 << m_pos());
         check("model_out_valid", 32'(out_valid), 32'(m_kind != 0));
         check("model_busy", 32'(busy), 32'(m_busy()));
         check("model_in_ready", 32'(in_ready), 32'(!m_busy()));
      end
   end

   task automatic cmd(input logic [1:0] m, input int s, input int d);
      @(negedge sys_clk);
      in_valid = 1'b1;
      in_mode  = m;
      in_sel   = enc(s);
      in_dwell = 8'(d);
      @(negedge sys_clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int bc;
      repeat (2) @(negedge sys_clk);
      chk_en = 1'b1;
      check("rst_out_0", 32'(out_0), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h1);
      sys_rst = 1'b0;
      cmd(2'b00, 5, 0);
      check("direct5", 32'(out_0), 32'h20);
      check("direct5_valid", 32'(out_valid), 32'h1);
      for (int i = 0; i < 8; i++) begin
         cmd(2'b00, i, 0);
         check("sweep", 32'(out_0), 32'h1 << i);
      end
      cmd(2'b01, 6, 0);
      check("up_start", 32'(out_0), 32'h40);
      for (int k = 1; k < 8; k++) begin
         @(negedge sys_clk);
         check("up_walk", 32'(out_0), 32'h1 << up_seq[k]);
         check("up_ready", 32'(in_ready), 32'h0);
         in_valid = (k == 3);
         in_mode  = 2'b00;
         in_sel   = enc(0);
      end
      @(negedge sys_clk);
      check("up_hold", 32'(out_0), 32'h20);
      check("up_hold_busy", 32'(busy), 32'h0);
      check("up_hold_ready", 32'(in_ready), 32'h1);
      cmd(2'b10, 1, 2);
      bc = 0;
      for (int j = 0; j < 30; j++) begin
         if (j > 0) @(negedge sys_clk);
         if (busy) bc++;
         if (j % 3 == 0 && j < 24) check("down_walk", 32'(out_0), 32'h1 << dn_seq[j / 3]);
      end
      check("down_busy_cycles", 32'(bc), 32'd24);
      check("down_hold", 32'(out_0), 32'h04);
      cmd(2'b11, 0, 0);
      check("clear_out", 32'(out_0), 32'h0);
      check("clear_valid", 32'(out_valid), 32'h0);
      cmd(2'b01, 2, 5);
      repeat (4) @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      check("midrst_out", 32'(out_0), 32'h0);
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_ready", 32'(in_ready), 32'h1);
      cmd(2'b00, 3, 0);
      check("after_rst", 32'(out_0), 32'h08);
`ifdef DEC_GRAY_IN_EN
      @(negedge sys_clk);
      in_valid = 1'b1;
      in_mode  = 2'b00;
      in_sel   = 3'b110;
      @(negedge sys_clk);
      in_valid = 1'b0;
      check("gray_110", 32'(out_0), 32'h10);
`endif
      @(negedge sys_clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
